// File: rtl/up_counter_pkg.sv
// Shared defaults and the increment/wrap rule for the modulo-N up counter.
package up_counter_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_MAX   = 15;
    localparam int unsigned DEF_RESET = 0;

    // Values above max are treated as terminal, so an out-of-range count recovers to 0 on the next edge.
    function automatic logic [31:0] next_count(input logic [31:0] cur, input logic [31:0] max);
        return (cur >= max) ? 32'd0 : cur + 32'd1;
    endfunction

endpackage

// File: rtl/up_counter_next.sv
// Combinational next-count and terminal-detect logic for up_counter_mod.
// With COUNTER_TC_EN defined, also flags when the next count is the terminal value.
module up_counter_next
    import up_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MAX_VAL = DEF_MAX
) (
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] next
`ifdef COUNTER_TC_EN
    ,
    output logic             next_tc
`endif
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    assign next = WIDTH'(next_count(32'(count), MAX_VAL));

`ifdef COUNTER_TC_EN
    // Looking at the next value lets tc come straight from a flop alongside count.
    assign next_tc = (next == MAX_W);
`endif

endmodule

// File: rtl/up_counter_mod.sv
// Free-running modulo-(MAX_VAL+1) up counter with asynchronous active-low reset.
// Optional registered terminal-count output tc is enabled by defining COUNTER_TC_EN.
module up_counter_mod
    import up_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_VAL   = DEF_MAX,
    parameter int unsigned RESET_VAL = DEF_RESET
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [WIDTH-1:0] count
`ifdef COUNTER_TC_EN
    ,
    output logic             tc
`endif
);

    if (WIDTH < 1 || WIDTH > 32
        || (64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1))
        || RESET_VAL > MAX_VAL) begin : g_bad_params
        $error("up_counter_mod: illegal WIDTH/MAX_VAL/RESET_VAL combination");
    end

    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] next;

`ifdef COUNTER_TC_EN
    localparam logic RESET_TC = (RESET_VAL == MAX_VAL);

    logic next_tc;

    up_counter_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .count   (count),
        .next    (next),
        .next_tc (next_tc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tc <= RESET_TC;
        end else begin
            tc <= next_tc;
        end
    end
`else
    up_counter_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .count (count),
        .next  (next)
    );
`endif

    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values, so readers in other processes see no race.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= RESET_W;
        end else begin
            count <= next;
        end
    end

endmodule

// File: tb/tb_up_counter_mod.sv
// Scoreboard bench for up_counter_mod: default 0..15 counter and a MAX_VAL=9/RESET_VAL=3 variant.
// Checks tc as well when COUNTER_TC_EN is defined.
module tb_up_counter_mod;

    logic       clk;
    logic       resetn;
    logic [3:0] count_a;
    logic [3:0] count_b;
`ifdef COUNTER_TC_EN
    logic       tc_a;
    logic       tc_b;
`endif

    up_counter_mod dut_a (
        .clk    (clk),
        .resetn (resetn),
        .count  (count_a)
`ifdef COUNTER_TC_EN
        ,
        .tc     (tc_a)
`endif
    );

    up_counter_mod #(
        .WIDTH     (4),
        .MAX_VAL   (9),
        .RESET_VAL (3)
    ) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .count  (count_b)
`ifdef COUNTER_TC_EN
        ,
        .tc     (tc_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   model_a;
    int   model_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int model_next(input int cur, input int max);
        return (cur == max) ? 0 : cur + 1;
    endfunction

    task automatic push_expected();
        exp_t e;
        e.a = 4'(model_a);
        e.b = 4'(model_b);
        sb.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_a"}, 32'(count_a), 32'(e.a));
        check({tag, "_b"}, 32'(count_b), 32'(e.b));
`ifdef COUNTER_TC_EN
        check({tag, "_tc_a"}, 32'(tc_a), 32'(e.a == 4'd15));
        check({tag, "_tc_b"}, 32'(tc_b), 32'(e.b == 4'd9));
`endif
    endtask

    // Asynchronous reset: the model jumps to the reset values and the DUT must follow at once.
    task automatic assert_reset_now(input string tag);
        resetn = 1'b0;
        model_a = 0;
        model_b = 3;
        push_expected();
        #1;
        pop_compare(tag);
    endtask

    task automatic tick(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (resetn) begin
                model_a = model_next(model_a, 15);
                model_b = model_next(model_b, 9);
            end else begin
                model_a = 0;
                model_b = 3;
            end
            push_expected();
            @(posedge clk);
            #1;
            pop_compare(tag);
        end
    endtask

    initial begin
        resetn  = 1'b1;
        model_a = 0;
        model_b = 3;

        #10;
        assert_reset_now("reset_t10");
        tick("reset_hold", 2);

        #4;
        resetn = 1'b1;
        tick("count_1_to_14", 14);

        #4;
        assert_reset_now("reset_midcycle");
        tick("reset_hold2", 2);

        #4;
        resetn = 1'b1;
        tick("wrap16", 16);
        tick("to_seven", 7);
        check("pre_coincident", 32'(count_a), 32'd7);

        @(posedge clk);
        assert_reset_now("reset_coincident");
        tick("reset_hold3", 1);

        #4;
        resetn = 1'b1;
        tick("variant_wrap", 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
